// File: rtl/lmdpl_dr_capture.sv
// Receive-side endpoint for LMDPL dual-rail gate networks: sequences precharge/evaluate,
// captures the resolved true rails as a single-rail word and flags protocol violations.
module lmdpl_dr_capture #(
   parameter int WIDTH        = 8,
   parameter int PRE_CYCLES   = 2,
   parameter int EVAL_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dr_t_i,
   input  logic [WIDTH-1:0] dr_f_i,
   output logic             pre_o,
   output logic             eval_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o,
   output logic             err_o,
   output logic [1:0]       err_code_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_EVAL = 2'd2
   } state_e;

   localparam logic [3:0] PRE_LAST  = 4'(PRE_CYCLES - 1);
   localparam logic [3:0] EVAL_LAST = 4'(EVAL_TIMEOUT - 1);

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_PRE   = 2'b01;
   localparam logic [1:0] ERR_CLASH = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   function automatic logic rails_quiet(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
      return ~|(t | f);
   endfunction

   function automatic logic rails_complete(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
      return &(t ^ f);
   endfunction

   function automatic logic rails_clash(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
      return |(t & f);
   endfunction

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic             pre_q;
   logic             eval_q;
   logic             busy_q;
   logic [WIDTH-1:0] q_q;
   logic             valid_q;
   logic             err_q;
   logic [1:0]       err_code_q;
   logic             quiet_s;
   logic             complete_s;
   logic             clash_s;

   assign cnt_d      = cnt_q + 4'd1;
   assign quiet_s    = rails_quiet(dr_t_i, dr_f_i);
   assign complete_s = rails_complete(dr_t_i, dr_f_i);
   assign clash_s    = rails_clash(dr_t_i, dr_f_i);

   // Transaction FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         pre_q      <= 1'b1;
         eval_q     <= 1'b0;
         busy_q     <= 1'b0;
         q_q        <= {WIDTH{1'b0}};
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q    <= ST_PRE;
                  cnt_q      <= 4'd0;
                  err_code_q <= ERR_NONE;
                  busy_q     <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
               pre_q  <= 1'b1;
               eval_q <= 1'b0;
            end
            ST_PRE: begin
               if (cnt_q == PRE_LAST) begin
                  if (quiet_s) begin
                     state_q <= ST_EVAL;
                     cnt_q   <= 4'd0;
                     pre_q   <= 1'b0;
                     eval_q  <= 1'b1;
                  end else begin
                     state_q    <= ST_IDLE;
                     busy_q     <= 1'b0;
                     err_q      <= 1'b1;
                     err_code_q <= ERR_PRE;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_EVAL: begin
               // Clash outranks completion: a word with any 11 pair is never captured.
               if (clash_s) begin
                  state_q    <= ST_IDLE;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_CLASH;
               end else if (complete_s) begin
                  state_q <= ST_IDLE;
                  q_q     <= dr_t_i;
                  valid_q <= 1'b1;
               end else if (cnt_q == EVAL_LAST) begin
                  state_q    <= ST_IDLE;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_TMO;
               end else begin
                  cnt_q <= cnt_d;
               end
               if (clash_s || complete_s || (cnt_q == EVAL_LAST)) begin
                  pre_q  <= 1'b1;
                  eval_q <= 1'b0;
                  busy_q <= 1'b0;
               end else begin
                  pre_q  <= 1'b0;
                  eval_q <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               pre_q   <= 1'b1;
               eval_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pre_o      = pre_q;
   assign eval_o     = eval_q;
   assign busy_o     = busy_q;
   assign q_o        = q_q;
   assign valid_o    = valid_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;

endmodule
